// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receive path.
// baud_gen derives its divisor from the same oversampling constant.
package uart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_MID_SAMPLE = DEF_OVERSAMPLE / 2 - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte stream from uart_rx to downstream byte consumers.
// The master drives the byte and its strobes; consumers attach as slave.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_error;
  logic                 busy;

  modport master (
    output data,
    output data_valid,
    output frame_error,
    output busy
  );

  modport slave (
    input data,
    input data_valid,
    input frame_error,
    input busy
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversampling tick; emits each byte
// with a one-clk valid strobe, or a one-clk framing-error strobe.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low on a tick
// START | counting to mid start bit to reject glitches
// DATA  | sampling data bits at mid-bit, LSB first
// STOP  | sampling stop bit at mid-bit, then back to IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int MID_SAMPLE = DEF_MID_SAMPLE
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      tick,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(MID_SAMPLE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t             state_q, state_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end

        START: begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            // Frame is LSB first, so shifting in at the MSB leaves bit 0 at the bottom.
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            // Leaving at mid-stop gives half a bit of slack for a back-to-back start.
            tick_cnt_d = '0;
            state_d    = IDLE;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d    = IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end
  end

  assign bus.data        = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.frame_error = ferr_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic,
// checked against an expected-event queue built from the frames sent.
module tb_uart_rx;

  logic clk;
  logic rst_n;
  logic tick;
  logic rx;
  int   div;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.DATA_BITS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick),
    .rx   (rx),
    .bus  (bus)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  int         checks;
  int         errors;
  int         n_valid;
  int         n_exp_valid;
  logic [7:0] last_good;
  logic       pv;
  logic       pe;
  exp_t       e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-clk tick every div clocks, changed on the falling edge.
  initial begin
    tick = 1'b0;
    forever begin
      for (int i = 0; i < div - 1; i++) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!tick);
    end
  endtask

  task automatic drive_bit(input logic v);
    #1 rx = v;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int gap);
    exp_t x;
    x.is_err = !stop_ok;
    x.val    = b;
    exp_q.push_back(x);
    if (stop_ok) n_exp_valid++;
    drive_bit(1'b0);
    check_eq("busy_in_frame", bus.busy, 1);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (stop_ok) begin
      check_eq("busy_after_stop", bus.busy, 0);
    end else begin
      drive_bit(1'b1);
      check_eq("busy_after_bad_stop", bus.busy, 0);
    end
    #1 rx = 1'b1;
    wait_ticks(gap);
  endtask

  // Strobe monitor: every strobe must match the next expected event.
  initial begin
    pv = 1'b0;
    pe = 1'b0;
    last_good = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_good = 8'h00;
        pv = 1'b0;
        pe = 1'b0;
      end else begin
        if (bus.data_valid || bus.frame_error) begin
          check_eq("no_overlap", bus.data_valid & bus.frame_error, 0);
          check_eq("pulse_width", (bus.data_valid & pv) | (bus.frame_error & pe), 0);
          check_eq("event_expected", exp_q.size() != 0, 1);
          if (bus.data_valid) n_valid++;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("event_kind", bus.frame_error, e.is_err);
            if (!e.is_err) last_good = e.val;
            check_eq(e.is_err ? "data_hold" : "data_byte", bus.data, last_good);
          end
        end
        pv = bus.data_valid;
        pe = bus.frame_error;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       ok;
    int         gap;
    checks = 0;
    errors = 0;
    n_valid = 0;
    n_exp_valid = 0;
    div   = 87;
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check_eq("rst_data", bus.data, 0);
    check_eq("rst_valid", bus.data_valid, 0);
    check_eq("rst_ferr", bus.frame_error, 0);
    check_eq("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(4);

    // 19200 baud at 27 MHz
    send_frame(8'h41, 1'b1, 4);
    div = 5;
    wait_ticks(4);

    send_frame(8'h55, 1'b1, 0);
    send_frame(8'hAA, 1'b1, 8);

    // Short low glitch must be rejected
    #1 rx = 1'b0;
    wait_ticks(4);
    check_eq("glitch_busy", bus.busy, 1);
    #1 rx = 1'b1;
    wait_ticks(8);
    check_eq("glitch_idle", bus.busy, 0);
    wait_ticks(8);

    send_frame(8'h3C, 1'b0, 4);
    send_frame(8'h0F, 1'b1, 4);

    // Reset mid-DATA of 0x7E: partial byte must vanish
    b = 8'h7E;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_data", bus.data, 0);
    check_eq("midrst_valid", bus.data_valid, 0);
    check_eq("midrst_ferr", bus.frame_error, 0);
    check_eq("midrst_busy", bus.busy, 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(20);
    check_eq("postrst_busy", bus.busy, 0);
    send_frame(8'h31, 1'b1, 4);

    for (int n = 0; n < 16; n++) begin
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 5) != 0);
      gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      send_frame(b, ok, gap);
    end

    wait_ticks(20);
    check_eq("pending_events", exp_q.size(), 0);
    check_eq("valid_count", n_valid, n_exp_valid);
    check_eq("final_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
